// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with EX/MEM and MEM/WB operand forwarding
// and load-use hazard detection, feeding the 64-bit ALU.
module id_ex_operand_stage #(
  parameter int XLEN = 64,
  parameter int RA_W = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            id_valid,
  input  logic [XLEN-1:0] id_rs1_data,
  input  logic [XLEN-1:0] id_rs2_data,
  input  logic [XLEN-1:0] id_imm,
  input  logic [RA_W-1:0] id_rs1,
  input  logic [RA_W-1:0] id_rs2,
  input  logic [RA_W-1:0] id_rd,
  input  logic            id_alu_src,
  input  logic [3:0]      id_alu_op,
  input  logic            id_reg_write,
  input  logic            id_mem_read,
  input  logic            id_mem_write,
  input  logic            id_mem_to_reg,
  input  logic            id_branch,
  input  logic            stall_in,
  input  logic            flush,
  input  logic            exmem_reg_write,
  input  logic [RA_W-1:0] exmem_rd,
  input  logic [XLEN-1:0] exmem_result,
  input  logic            memwb_reg_write,
  input  logic [RA_W-1:0] memwb_rd,
  input  logic [XLEN-1:0] memwb_result,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [3:0]      alu_op,
  output logic [XLEN-1:0] store_data,
  output logic [RA_W-1:0] ex_rd,
  output logic            ex_valid,
  output logic            ex_reg_write,
  output logic            ex_mem_read,
  output logic            ex_mem_write,
  output logic            ex_mem_to_reg,
  output logic            ex_branch,
  output logic            load_use_stall
);

  typedef struct packed {
    logic            valid;
    logic [RA_W-1:0] rs1;
    logic [RA_W-1:0] rs2;
    logic [RA_W-1:0] rd;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
    logic            alu_src;
    logic [3:0]      alu_op;
    logic            reg_write;
    logic            mem_read;
    logic            mem_write;
    logic            mem_to_reg;
    logic            branch;
  } id_ex_t;

  id_ex_t q;
  id_ex_t load_d;
  id_ex_t bubble_d;

  always_comb begin
    load_d            = '0;
    load_d.valid      = id_valid;
    load_d.rs1        = id_rs1;
    load_d.rs2        = id_rs2;
    load_d.rd         = id_rd;
    load_d.rs1_data   = id_rs1_data;
    load_d.rs2_data   = id_rs2_data;
    load_d.imm        = id_imm;
    load_d.alu_src    = id_alu_src;
    load_d.alu_op     = id_alu_op;
    load_d.reg_write  = id_valid & id_reg_write;
    load_d.mem_read   = id_valid & id_mem_read;
    load_d.mem_write  = id_valid & id_mem_write;
    load_d.mem_to_reg = id_valid & id_mem_to_reg;
    load_d.branch     = id_valid & id_branch;
  end

  // Bubble keeps data fields; only validity and control are cleared.
  always_comb begin
    bubble_d            = q;
    bubble_d.valid      = 1'b0;
    bubble_d.alu_op     = 4'b0000;
    bubble_d.reg_write  = 1'b0;
    bubble_d.mem_read   = 1'b0;
    bubble_d.mem_write  = 1'b0;
    bubble_d.mem_to_reg = 1'b0;
    bubble_d.branch     = 1'b0;
  end

  assign load_use_stall = q.valid & q.mem_read & id_valid
                        & (q.rd != '0)
                        & ((q.rd == id_rs1) | (q.rd == id_rs2));

  always_ff @(posedge clk) begin
    if (reset)               q <= '0;
    else if (flush)          q <= bubble_d;
    else if (stall_in)       q <= q;
    else if (load_use_stall) q <= bubble_d;
    else                     q <= load_d;
  end

  function automatic logic [XLEN-1:0] fwd(
    input logic [RA_W-1:0] rs,
    input logic [XLEN-1:0] rf
  );
    if (exmem_reg_write && exmem_rd != '0 && exmem_rd == rs)
      return exmem_result;
    else if (memwb_reg_write && memwb_rd != '0 && memwb_rd == rs)
      return memwb_result;
    else
      return rf;
  endfunction

  logic [XLEN-1:0] rs1_fwd;
  logic [XLEN-1:0] rs2_fwd;

  assign rs1_fwd       = fwd(q.rs1, q.rs1_data);
  assign rs2_fwd       = fwd(q.rs2, q.rs2_data);
  assign alu_a         = rs1_fwd;
  assign store_data    = rs2_fwd;
  assign alu_b         = q.alu_src ? q.imm : rs2_fwd;
  assign alu_op        = q.alu_op;
  assign ex_rd         = q.rd;
  assign ex_valid      = q.valid;
  assign ex_reg_write  = q.reg_write;
  assign ex_mem_read   = q.mem_read;
  assign ex_mem_write  = q.mem_write;
  assign ex_mem_to_reg = q.mem_to_reg;
  assign ex_branch     = q.branch;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Directed bench for id_ex_operand_stage: vector table plus
// hand sequences for load-use, stall/flush and reset corners.
module tb_id_ex_operand_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        id_valid;
  logic [63:0] id_rs1_data, id_rs2_data, id_imm;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic        id_alu_src;
  logic [3:0]  id_alu_op;
  logic        id_reg_write, id_mem_read, id_mem_write;
  logic        id_mem_to_reg, id_branch;
  logic        stall_in, flush;
  logic        exmem_reg_write, memwb_reg_write;
  logic [4:0]  exmem_rd, memwb_rd;
  logic [63:0] exmem_result, memwb_result;
  logic [63:0] alu_a, alu_b, store_data;
  logic [3:0]  alu_op;
  logic [4:0]  ex_rd;
  logic        ex_valid, ex_reg_write, ex_mem_read;
  logic        ex_mem_write, ex_mem_to_reg, ex_branch;
  logic        load_use_stall;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  id_ex_operand_stage dut (
    .clk(clk), .reset(reset), .id_valid(id_valid),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
    .id_imm(id_imm), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rd(id_rd), .id_alu_src(id_alu_src),
    .id_alu_op(id_alu_op), .id_reg_write(id_reg_write),
    .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .id_mem_to_reg(id_mem_to_reg), .id_branch(id_branch),
    .stall_in(stall_in), .flush(flush),
    .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd),
    .exmem_result(exmem_result),
    .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd),
    .memwb_result(memwb_result),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .store_data(store_data), .ex_rd(ex_rd),
    .ex_valid(ex_valid), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_mem_to_reg(ex_mem_to_reg), .ex_branch(ex_branch),
    .load_use_stall(load_use_stall)
  );

  typedef struct packed {
    logic        v;
    logic [4:0]  rs1, rs2, rd;
    logic [63:0] d1, d2, imm;
    logic        src;
    logic [3:0]  op;
    logic [4:0]  ctl;
    logic        exw;
    logic [4:0]  exrd;
    logic [63:0] exres;
    logic        wbw;
    logic [4:0]  wbrd;
    logic [63:0] wbres;
    logic        ev;
    logic [63:0] ea, eb, esd;
    logic [3:0]  eop;
    logic [4:0]  erd;
    logic [4:0]  ectl;
  } vec_t;

  vec_t tv [8];

  function automatic logic [4:0] ctl_out();
    return {ex_reg_write, ex_mem_read, ex_mem_write,
            ex_mem_to_reg, ex_branch};
  endfunction

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [4:0] rd,
                       input logic [63:0] d1, input logic [63:0] d2,
                       input logic [63:0] imm, input logic src,
                       input logic [3:0] op, input logic [4:0] ctl);
    id_valid    = v;
    id_rs1      = rs1;
    id_rs2      = rs2;
    id_rd       = rd;
    id_rs1_data = d1;
    id_rs2_data = d2;
    id_imm      = imm;
    id_alu_src  = src;
    id_alu_op   = op;
    {id_reg_write, id_mem_read, id_mem_write,
     id_mem_to_reg, id_branch} = ctl;
  endtask

  task automatic fwd_off();
    exmem_reg_write = 1'b0;
    exmem_rd        = 5'd0;
    exmem_result    = 64'h0;
    memwb_reg_write = 1'b0;
    memwb_rd        = 5'd0;
    memwb_result    = 64'h0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    tv[0] = '{1'b1, 5'd1, 5'd2, 5'd3, 64'h5, 64'h7, 64'h0, 1'b0,
              4'b0010, 5'h00, 1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 64'h0,
              1'b1, 64'h5, 64'h7, 64'h7, 4'b0010, 5'd3, 5'h00};
    tv[1] = '{1'b0, 5'd5, 5'd6, 5'd2, 64'h10, 64'h20, 64'h30, 1'b1,
              4'b0110, 5'h1f, 1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 64'h0,
              1'b0, 64'h10, 64'h30, 64'h20, 4'b0110, 5'd2, 5'h00};
    tv[2] = '{1'b1, 5'd3, 5'd4, 5'd7, 64'h33, 64'h44, 64'h0, 1'b0,
              4'b1100, 5'h11, 1'b1, 5'd3, 64'hAA, 1'b1, 5'd3, 64'hBB,
              1'b1, 64'hAA, 64'h44, 64'h44, 4'b1100, 5'd7, 5'h11};
    tv[3] = '{1'b1, 5'd3, 5'd4, 5'd7, 64'h33, 64'h44, 64'h0, 1'b0,
              4'b1100, 5'h11, 1'b0, 5'd3, 64'hAA, 1'b1, 5'd3, 64'hBB,
              1'b1, 64'hBB, 64'h44, 64'h44, 4'b1100, 5'd7, 5'h11};
    tv[4] = '{1'b1, 5'd0, 5'd0, 5'd1, 64'h11, 64'h22, 64'h0, 1'b0,
              4'b0001, 5'h10, 1'b1, 5'd0, 64'hAA, 1'b1, 5'd0, 64'hBB,
              1'b1, 64'h11, 64'h22, 64'h22, 4'b0001, 5'd1, 5'h10};
    tv[5] = '{1'b1, 5'd7, 5'd9, 5'd0, 64'h1, 64'h99,
              64'hFFFF_FFFF_FFFF_FFF0, 1'b1,
              4'b0010, 5'h04, 1'b1, 5'd7, 64'h123, 1'b1, 5'd9, 64'h9,
              1'b1, 64'h123, 64'hFFFF_FFFF_FFFF_FFF0, 64'h9,
              4'b0010, 5'd0, 5'h04};
    tv[6] = '{1'b1, 5'd2, 5'd8, 5'd10, 64'h3, 64'h5, 64'h0, 1'b0,
              4'b1110, 5'h01, 1'b1, 5'd8, 64'hE, 1'b1, 5'd8, 64'hF,
              1'b1, 64'h3, 64'hE, 64'hE, 4'b1110, 5'd10, 5'h01};
    tv[7] = '{1'b1, 5'd8, 5'd8, 5'd11, 64'h7, 64'h8, 64'h55, 1'b1,
              4'b0000, 5'h10, 1'b0, 5'd8, 64'hE, 1'b1, 5'd8, 64'hF,
              1'b1, 64'hF, 64'h55, 64'hF, 4'b0000, 5'd11, 5'h10};

    // Reset with a live instruction on the decode side.
    reset = 1'b1; stall_in = 1'b0; flush = 1'b0;
    fwd_off();
    drive(1'b1, 5'd1, 5'd2, 5'd3, 64'h5, 64'h7, 64'h0, 1'b0,
          4'b0010, 5'h1f);
    tick();
    chk("rst_valid", 64'(ex_valid), 64'h0);
    chk("rst_ctl", 64'(ctl_out()), 64'h0);
    chk("rst_op", 64'(alu_op), 64'h0);
    chk("rst_rd", 64'(ex_rd), 64'h0);
    chk("rst_a", alu_a, 64'h0);
    chk("rst_b", alu_b, 64'h0);
    chk("rst_sd", store_data, 64'h0);
    reset = 1'b0;

    for (int i = 0; i < 8; i++) begin
      drive(tv[i].v, tv[i].rs1, tv[i].rs2, tv[i].rd, tv[i].d1,
            tv[i].d2, tv[i].imm, tv[i].src, tv[i].op, tv[i].ctl);
      exmem_reg_write = tv[i].exw;
      exmem_rd        = tv[i].exrd;
      exmem_result    = tv[i].exres;
      memwb_reg_write = tv[i].wbw;
      memwb_rd        = tv[i].wbrd;
      memwb_result    = tv[i].wbres;
      tick();
      chk($sformatf("v%0d_valid", i), 64'(ex_valid), 64'(tv[i].ev));
      chk($sformatf("v%0d_a", i), alu_a, tv[i].ea);
      chk($sformatf("v%0d_b", i), alu_b, tv[i].eb);
      chk($sformatf("v%0d_sd", i), store_data, tv[i].esd);
      chk($sformatf("v%0d_op", i), 64'(alu_op), 64'(tv[i].eop));
      chk($sformatf("v%0d_rd", i), 64'(ex_rd), 64'(tv[i].erd));
      chk($sformatf("v%0d_ctl", i), 64'(ctl_out()), 64'(tv[i].ectl));
      chk($sformatf("v%0d_lus", i), 64'(load_use_stall), 64'h0);
    end

    // Load-use: load to x4, dependent instruction reads x4 via rs2.
    fwd_off();
    drive(1'b1, 5'd1, 5'd2, 5'd4, 64'h1, 64'h2, 64'h0, 1'b0,
          4'b0010, 5'h1a);
    tick();
    chk("lu_ld_mr", 64'(ex_mem_read), 64'h1);
    drive(1'b1, 5'd6, 5'd4, 5'd9, 64'h61, 64'h62, 64'h0, 1'b0,
          4'b0010, 5'h10);
    #1;
    chk("lu_stall", 64'(load_use_stall), 64'h1);
    // A downstream stall holds the load; the hazard stays visible.
    stall_in = 1'b1;
    tick();
    chk("lu_hold_mr", 64'(ex_mem_read), 64'h1);
    chk("lu_hold_stall", 64'(load_use_stall), 64'h1);
    stall_in = 1'b0;
    tick();
    chk("lu_bub_valid", 64'(ex_valid), 64'h0);
    chk("lu_bub_ctl", 64'(ctl_out()), 64'h0);
    chk("lu_bub_op", 64'(alu_op), 64'h0);
    chk("lu_bub_stall", 64'(load_use_stall), 64'h0);
    tick();
    chk("lu_ld_valid", 64'(ex_valid), 64'h1);
    chk("lu_ld_rd", 64'(ex_rd), 64'd9);
    chk("lu_ld_a", alu_a, 64'h61);
    chk("lu_ld_ctl", 64'(ctl_out()), 64'h10);

    // A load targeting x0 never creates a hazard.
    drive(1'b1, 5'd1, 5'd2, 5'd0, 64'h1, 64'h2, 64'h0, 1'b0,
          4'b0010, 5'h1a);
    tick();
    drive(1'b1, 5'd0, 5'd0, 5'd3, 64'h0, 64'h0, 64'h0, 1'b0,
          4'b0010, 5'h10);
    #1;
    chk("lu_x0", 64'(load_use_stall), 64'h0);

    // Stall for three cycles with changing decode inputs.
    drive(1'b1, 5'd12, 5'd13, 5'd5, 64'h1234, 64'h5678, 64'h0,
          1'b0, 4'b0110, 5'h11);
    tick();
    stall_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 5'(i + 20), 5'(i + 24), 5'(i + 1),
            64'(i + 100), 64'(i + 200), 64'h0, 1'b1,
            4'b0001, 5'h04);
      tick();
      chk($sformatf("st%0d_valid", i), 64'(ex_valid), 64'h1);
      chk($sformatf("st%0d_rd", i), 64'(ex_rd), 64'd5);
      chk($sformatf("st%0d_op", i), 64'(alu_op), 64'b0110);
      chk($sformatf("st%0d_a", i), alu_a, 64'h1234);
      chk($sformatf("st%0d_b", i), alu_b, 64'h5678);
      chk($sformatf("st%0d_ctl", i), 64'(ctl_out()), 64'h11);
    end
    flush = 1'b1;
    tick();
    chk("fl_valid", 64'(ex_valid), 64'h0);
    chk("fl_op", 64'(alu_op), 64'h0);
    chk("fl_ctl", 64'(ctl_out()), 64'h0);
    flush = 1'b0;
    stall_in = 1'b0;

    // Reset during a stall with a valid instruction held.
    drive(1'b1, 5'd3, 5'd3, 5'd6, 64'h9, 64'h9, 64'h0, 1'b0,
          4'b1110, 5'h1f);
    tick();
    chk("rs_pre_valid", 64'(ex_valid), 64'h1);
    drive(1'b0, 5'd0, 5'd0, 5'd0, 64'h0, 64'h0, 64'h0, 1'b0,
          4'b0000, 5'h00);
    stall_in = 1'b1;
    reset = 1'b1;
    tick();
    chk("rs_valid", 64'(ex_valid), 64'h0);
    chk("rs_op", 64'(alu_op), 64'h0);
    chk("rs_ctl", 64'(ctl_out()), 64'h0);
    chk("rs_rd", 64'(ex_rd), 64'h0);
    reset = 1'b0;
    stall_in = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/id_ex_operand_stage.md
Name: id_ex_operand_stage

Overview:
- ID/EX pipeline register with operand forwarding. Sits directly upstream of the 64-bit ALU.
- Captures decoded operands and control from the decode stage. Resolves data hazards by forwarding from EX/MEM and MEM/WB, and detects load-use hazards.
- Drives the ALU `a`, `b` and `ALUOp` inputs. Passes memory/writeback control downstream.

Parameters:
- XLEN, 64, datapath width.
- RA_W, 5, register-address width.

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- id_valid  in  1  decode stage presents a real instruction
- id_rs1_data, id_rs2_data  in  XLEN  register-file read data
- id_imm  in  XLEN  sign-extended immediate
- id_rs1, id_rs2, id_rd  in  RA_W  register addresses
- id_alu_src  in  1  1 = b takes immediate
- id_alu_op  in  4  ALU operation code (0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 1100 NOR, 1110 BLT)
- id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_branch  in  1  control bits
- stall_in  in  1  downstream stall; hold stage contents
- flush  in  1  squash stage contents (taken branch)
- exmem_reg_write  in  1;  exmem_rd  in  RA_W;  exmem_result  in  XLEN
- memwb_reg_write  in  1;  memwb_rd  in  RA_W;  memwb_result  in  XLEN
- alu_a, alu_b  out  XLEN  ALU operands
- alu_op  out  4  ALU operation
- store_data  out  XLEN  forwarded rs2 for stores
- ex_rd  out  RA_W
- ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_branch  out  1
- load_use_stall  out  1  hold PC and IF/ID, present same instruction again

Behaviour:
- State: valid, rs1, rs2, rd, rs1_data, rs2_data, imm, alu_src, alu_op and the five control bits. All registered, 1-cycle latency from id_* to outputs.
- Reset: all state to 0. Consequences:
  - ex_valid = 0 and all control outputs = 0.
  - alu_op = 0000, ex_rd = 0.
  - alu_a/alu_b/store_data = 0 unless forwarding matches (rs fields = 0, so forwarding never matches; outputs are 0).
- Update priority each edge: reset > flush > stall_in > load_use_stall > load.
  - flush: bubble. valid = 0, control bits = 0, alu_op = 0000; data fields don't care.
  - stall_in (no flush): every field holds.
  - load_use_stall (no flush, no stall_in): bubble, as for flush.
  - Otherwise: load all id_* fields. valid = id_valid. Control bits gated by id_valid (zero when id_valid = 0).
- load_use_stall is combinational:
  - Asserted when ex_valid & ex_mem_read & id_valid & (ex_rd != 0) & (ex_rd == id_rs1 | ex_rd == id_rs2).
  - Conservative: id_rs2 is compared even for immediate-form instructions.
  - Still asserted while stall_in is high.
  - Deasserts the cycle after the bubble is inserted (stage then holds no load).
- Forwarding is combinational on registered rs1/rs2. For each source:
  - If exmem_reg_write & exmem_rd != 0 & exmem_rd == rs, use exmem_result.
  - Else if memwb_reg_write & memwb_rd != 0 & memwb_rd == rs, use memwb_result.
  - Else use the registered register-file data.
  - EX/MEM wins over MEM/WB. x0 is never forwarded.
- Operand outputs:
  - alu_a = forwarded rs1.
  - store_data = forwarded rs2.
  - alu_b = imm if alu_src, else forwarded rs2.
- Forwarding applies regardless of valid. Bubbles carry zeroed control, so their ALU result is harmless.
- Control outputs mirror registered bits. ex_rd = registered rd.
- Reset asserted mid-stall or mid-flush: reset wins; stage empty next cycle.

Test Plan:
- Reset, then id_valid = 1, rs1_data = 5, rs2_data = 7, alu_op = 0010, alu_src = 0, control bits 0 -> next cycle ex_valid = 1, alu_a = 5, alu_b = 7, alu_op = 0010. Prior to load, all outputs 0.
- Forwarding priority: stage holds rs1 = 3. exmem_rd = 3 (write, result 0xAA) and memwb_rd = 3 (write, result 0xBB) -> alu_a = 0xAA. Drop exmem_reg_write -> alu_a = 0xBB. Set both rd = 0 with rs1 = 0 -> alu_a = registered data.
- Load-use: stage holds mem_read = 1, rd = 4. Decode presents id_valid = 1, id_rs2 = 4 -> load_use_stall = 1. Next cycle ex_valid = 0, controls 0, load_use_stall = 0. Following edge loads the decode instruction.
- Immediate select: alu_src = 1, imm = 0xFFFF_FFFF_FFFF_FFF0, rs2 forwarded value 9 -> alu_b = 0xFFFF_FFFF_FFFF_FFF0, store_data = 9.
- stall_in = 1 for 3 cycles with changing id_* -> outputs unchanged. Assert flush together with stall_in -> next cycle ex_valid = 0.
- Reset asserted while stall_in = 1 and stage valid -> next cycle ex_valid = 0, alu_op = 0000, all control 0.
